fetch_buffer: RTL and testbench

Parametrised instruction-fetch unit with a prefetch queue. It replaces the single-cycle combinational fetch stage. It issues sequential PC requests to instruction memory over a valid/ready handshake and tracks in-flight requests with a credit counter. Returned instructions are buffered with their PCs in a DEPTH-entry FIFO. On a redirect from execute/branch resolution it flushes cleanly and discards stale responses. It sits between the PC-select logic/instruction memory port and the decode stage's input register.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_buffer_sync_fifo.sv | 61 ++++++
 rtl/fetch_buffer.sv | 163 ++++++++++++++++
 tb/tb_fetch_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch buffer.
package fetch_pkg;

  // Fetch control states: one idle cycle out of reset, then steady-state fetching
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          INSTR_STEP       = 4;

  // Canonical layout of a buffered fetch entry at the default widths
  localparam int ENTRY_XLEN = 64;
  localparam int ENTRY_ILEN = 32;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage, occupancy count and flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop so a full or empty queue never has its pointers disturbed
  always_comb begin
    do_push = push && (count != (AW+1)'(DEPTH));
    do_pop  = pop && (count != '0);
  end

  // Storage, pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: prefetching fetch unit with credit-limited requests and redirect flush.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [ILEN-1:0] mem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_o_valid,
  input  logic            fetch_i_ready,
  output logic [XLEN-1:0] fetch_o_pc,
  output logic [ILEN-1:0] fetch_o_instr,
  output logic [XLEN-1:0] fetch_o_pre_pc
);

  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_STEP);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] pc_head;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   pc_count;
  logic [CW-1:0]   out_count;
  logic            req_hs;
  logic            resp_keep;
  logic            dec_hs;
  logic            credit_ok;
  entry_t          enq_entry;
  entry_t          head_entry;

  // Handshakes and the credit limit shared by issue, drop and queue control
  always_comb begin
    req_hs           = mem_req_valid && mem_req_ready;
    resp_keep        = mem_resp_valid && (drop == '0) && !redirect_valid;
    dec_hs           = fetch_o_valid && fetch_i_ready;
    credit_ok        = ({1'b0, out_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
    redirect_aligned = redirect_pc & ~XLEN'(3);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a single idle cycle after reset, then fetch forever
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Request issue: only in RUN and only while buffered plus in-flight entries leave room
  always_comb begin
    mem_req_valid = 1'b0;
    if (state == RUN) begin
      mem_req_valid = credit_ok;
    end
  end

  // In-flight count after this cycle's request and response
  always_comb begin
    outstanding_next = outstanding;
    case ({req_hs, mem_resp_valid})
      2'b10:   outstanding_next = outstanding + 1'b1;
      2'b01:   outstanding_next = outstanding - 1'b1;
      default: outstanding_next = outstanding;
    endcase
  end

  // Fetch PC, in-flight count and stale-response drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        req_pc <= redirect_aligned;
        drop   <= outstanding_next;
      end else begin
        if (req_hs) begin
          req_pc <= req_pc + STEP;
        end
        if (mem_resp_valid && (drop != '0)) begin
          drop <= drop - 1'b1;
        end
      end
    end
  end

  assign mem_req_addr = req_pc;

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (req_hs),
    .push_data (req_pc),
    .pop       (resp_keep),
    .head_data (pc_head),
    .count     (pc_count)
  );

  assign enq_entry.pc    = pc_head;
  assign enq_entry.instr = mem_resp_data;

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data (enq_entry),
    .pop       (dec_hs),
    .head_data (head_entry),
    .count     (out_count)
  );

  assign fetch_o_valid  = (out_count != '0);
  assign fetch_o_pc     = head_entry.pc;
  assign fetch_o_instr  = head_entry.instr;
  assign fetch_o_pre_pc = head_entry.pc + STEP;

  // Memory must never answer without a pending request; kept responses always have a PC
  a_resp_has_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    mem_resp_valid |-> (outstanding != '0));
  a_kept_resp_has_pc: assert property (@(posedge clk) disable iff (!rst_n)
    resp_keep |-> (pc_count != '0));

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed tests for fetch_buffer with a latency-configurable memory model.
module tb_fetch_buffer;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid = 1'b0;
  logic [ILEN-1:0] mem_resp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            fetch_o_valid;
  logic            fetch_i_ready = 1'b0;
  logic [XLEN-1:0] fetch_o_pc;
  logic [ILEN-1:0] fetch_o_instr;
  logic [XLEN-1:0] fetch_o_pre_pc;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } mem_txn_t;

  mem_txn_t mem_q[$];
  int cyc = 0;
  int lat = 1;
  int req_count = 0;
  int checks = 0;
  int failures = 0;

  fetch_buffer #(
    .XLEN     (XLEN),
    .ILEN     (ILEN),
    .DEPTH    (DEPTH),
    .RESET_PC (64'h0000_0000_8000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_o_valid  (fetch_o_valid),
    .fetch_i_ready  (fetch_i_ready),
    .fetch_o_pc     (fetch_o_pc),
    .fetch_o_instr  (fetch_o_instr),
    .fetch_o_pre_pc (fetch_o_pre_pc)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Instruction word the memory model returns for a given address
  function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Head-of-queue check: valid flag, and when valid the pc, predicted pc and instruction
  task automatic checkHead(input string tag, input logic v, input logic [XLEN-1:0] pc,
                           input logic [XLEN-1:0] pre);
    checkOutput({tag, "_valid"}, 64'(fetch_o_valid), 64'(v));
    if (v) begin
      checkOutput({tag, "_pc"}, fetch_o_pc, pc);
      checkOutput({tag, "_pre_pc"}, fetch_o_pre_pc, pre);
      checkOutput({tag, "_instr"}, 64'(fetch_o_instr), 64'(instr_of(pc)));
    end
  endtask

  // One clock cycle: drive inputs at negedge, model memory, sample 1 time unit after posedge
  task automatic applyStimulus(input logic mrdy, input logic drdy, input logic rv,
                               input logic [XLEN-1:0] rpc);
    mem_txn_t t;
    @(negedge clk);
    mem_req_ready  = mrdy;
    fetch_i_ready  = drdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
    if (mem_req_valid && mem_req_ready) begin
      t.addr = mem_req_addr;
      t.due  = cyc + lat;
      mem_q.push_back(t);
      req_count++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_i_ready  = 1'b0;
    mem_q.delete();
    req_count = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("rst_req_addr", mem_req_addr, 64'h8000_0000);
    checkOutput("rst_fetch_valid", 64'(fetch_o_valid), 64'd0);
    checkOutput("rst_fetch_pc", fetch_o_pc, 64'd0);
    checkOutput("rst_fetch_instr", 64'(fetch_o_instr), 64'd0);
    checkOutput("rst_pre_pc", fetch_o_pre_pc, 64'd4);
    rst_n = 1'b1;
    checkOutput("boot_no_req", 64'(mem_req_valid), 64'd0);

    // Streaming: 1-cycle memory, everything ready, one instruction per cycle
    lat = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t1_first_req_valid", 64'(mem_req_valid), 64'd1);
    checkOutput("t1_first_req_addr", mem_req_addr, 64'h8000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t1_second_req_addr", mem_req_addr, 64'h8000_0004);
    checkOutput("t1_not_yet_valid", 64'(fetch_o_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkHead("t1_stream", 1'b1, 64'h8000_0000 + 64'(4 * k), 64'h8000_0004 + 64'(4 * k));
    end

    // Decode stalled: credit stops issue after DEPTH requests, head holds
    doReset();
    lat = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      if (i >= 1) checkHead("t2_stall_head", 1'b1, 64'h8000_0000, 64'h8000_0004);
    end
    checkOutput("t2_req_count", 64'(req_count), 64'd4);
    checkOutput("t2_req_blocked", 64'(mem_req_valid), 64'd0);

    // 3-cycle memory, redirect with 3 in flight: all old responses discarded
    doReset();
    lat = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t3_three_issued", 64'(req_count), 64'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h1000_0002);
    checkOutput("t3_redir_fetch_valid", 64'(fetch_o_valid), 64'd0);
    checkOutput("t3_redir_req_valid", 64'(mem_req_valid), 64'd1);
    checkOutput("t3_redir_req_addr", mem_req_addr, 64'h1000_0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkHead("t3_drained", 1'b0, '0, '0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkHead("t3_new_first", 1'b1, 64'h1000_0000, 64'h1000_0004);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkHead("t3_new_second", 1'b1, 64'h1000_0004, 64'h1000_0008);

    // Redirect coinciding with a request handshake and a response
    doReset();
    lat = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h2000_0000);
    checkOutput("t4_hs_in_redirect", 64'(req_count), 64'd2);
    checkOutput("t4_redir_fetch_valid", 64'(fetch_o_valid), 64'd0);
    checkOutput("t4_redir_req_addr", mem_req_addr, 64'h2000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkHead("t4_stale_dropped", 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkHead("t4_new_first", 1'b1, 64'h2000_0000, 64'h2000_0004);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkHead("t4_new_second", 1'b1, 64'h2000_0004, 64'h2000_0008);

    // Address wrap at the top of the address space, misaligned redirect target
    doReset();
    lat = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("t5_aligned_addr", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t5_wrapped_addr", mem_req_addr, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkHead("t5_top_entry", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkHead("t5_zero_entry", 1'b1, 64'd0, 64'd4);

    // Asynchronous reset while two entries are buffered
    doReset();
    lat = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkHead("t6_before_reset", 1'b1, 64'h8000_0000, 64'h8000_0004);
    #2;
    rst_n = 1'b0;
    mem_resp_valid = 1'b0;
    mem_q.delete();
    #1;
    checkOutput("t6_async_fetch_valid", 64'(fetch_o_valid), 64'd0);
    checkOutput("t6_async_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("t6_async_req_addr", mem_req_addr, 64'h8000_0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t6_restart_valid", 64'(mem_req_valid), 64'd1);
    checkOutput("t6_restart_addr", mem_req_addr, 64'h8000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t6_restart_next", mem_req_addr, 64'h8000_0004);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkHead("t6_restart_head", 1'b1, 64'h8000_0000, 64'h8000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
